// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use bubbles, branch flush and memory freeze control for the ID stage.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles/flush_count performance counters.
module hazard_ctrl_unit #(
   parameter int REG_ADDR_W      = 4,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int MAX_WAIT        = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rn,
   input  logic                  id_use_rm,
   input  logic                  id_use_rd,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  nop_select,
   output logic                  pc_enable,
   output logic                  if_id_enable,
   output logic                  if_id_flush,
   output logic                  pipe_freeze,
   output logic                  stall_active,
   output logic                  timeout_err,
   output logic [15:0]           stall_cycles,
   output logic [15:0]           flush_count
);
   typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

   localparam logic [3:0] LU_RELOAD  = 4'(LOAD_USE_CYCLES - 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_t     state_q, state_d, ret_q, ret_d, eff_state;
   logic [3:0] stall_cnt_q, stall_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_q, timeout_d;
   logic       load_use;

   assign load_use = ex_mem_read && ex_rd != '1 &&
                     ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd) ||
                      (id_use_rd && id_rd == ex_rd));
   // Once memory releases, the frozen state behaves exactly like the state it interrupted.
   assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         ret_q       <= RUN;
         stall_cnt_q <= 4'd0;
         wait_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         stall_cnt_q <= stall_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      stall_cnt_d = stall_cnt_q;
      wait_cnt_d  = 8'd0;
      timeout_d   = timeout_q;
      if (mem_busy) begin
         state_d    = FREEZE;
         ret_d      = (state_q == FREEZE) ? ret_q : state_q;
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
         timeout_d  = timeout_q || wait_cnt_d == WAIT_LIMIT;
      end else if (eff_state == STALL) begin
         stall_cnt_d = stall_cnt_q - 4'd1;
         state_d     = (stall_cnt_q == 4'd1) ? RUN : STALL;
      end else begin
         state_d     = (load_use && LOAD_USE_CYCLES > 1) ? STALL : RUN;
         stall_cnt_d = load_use ? LU_RELOAD : stall_cnt_q;
      end
   end

   always_comb begin
      nop_select   = 1'b0;
      pc_enable    = 1'b1;
      if_id_enable = 1'b1;
      if_id_flush  = 1'b0;
      pipe_freeze  = 1'b0;
      if (reset) begin
         nop_select   = 1'b1;
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
      end else if (mem_busy) begin
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
         pipe_freeze  = 1'b1;
      end else if (eff_state == STALL || load_use) begin
         nop_select   = 1'b1;
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
      end else begin
         if_id_flush  = branch_taken;
      end
   end

   assign stall_active = !reset && state_q != RUN;
   assign timeout_err  = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles_q, flush_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= 16'h0000;
         flush_count_q  <= 16'h0000;
      end else begin
         if ((nop_select || pipe_freeze) && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
         if (if_id_flush && flush_count_q != 16'hFFFF) flush_count_q <= flush_count_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 16'h0000;
   assign flush_count  = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: two instances (3-bubble/255-wait and 1-bubble/5-wait) checked cycle by cycle
// against a pending-bubble / freeze-run model through a scoreboard queue.
module tb_hazard_ctrl_unit;
   typedef struct packed {
      logic        nop, pce, ife, fl, frz, sa, to;
      logic [15:0] sc, fc;
   } exp_t;
   typedef struct packed {
      exp_t a, b;
   } pair_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] id_rn, id_rm, id_rd, ex_rd;
   logic       id_use_rn, id_use_rm, id_use_rd, ex_mem_read, branch_taken, mem_busy;
   logic [1:0] nop, pce, ife, fl, frz, sa, to;
   logic [15:0] sc [2];
   logic [15:0] fc [2];

   pair_t sbq[$];
   int    vectors = 0, miscompares = 0, cyc = 0;
   int    pend[2], frun[2], sc_m[2], fc_m[2];
   bit    busy_prev[2], to_m[2];

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_ADDR_W(4), .LOAD_USE_CYCLES(3), .MAX_WAIT(255)) dut_a (
      .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .nop_select(nop[0]), .pc_enable(pce[0]), .if_id_enable(ife[0]), .if_id_flush(fl[0]),
      .pipe_freeze(frz[0]), .stall_active(sa[0]), .timeout_err(to[0]),
      .stall_cycles(sc[0]), .flush_count(fc[0]));

   hazard_ctrl_unit #(.REG_ADDR_W(4), .LOAD_USE_CYCLES(1), .MAX_WAIT(5)) dut_b (
      .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .nop_select(nop[1]), .pc_enable(pce[1]), .if_id_enable(ife[1]), .if_id_flush(fl[1]),
      .pipe_freeze(frz[1]), .stall_active(sa[1]), .timeout_err(to[1]),
      .stall_cycles(sc[1]), .flush_count(fc[1]));

   // Reference: a count of bubbles still owed and the length of the current freeze run.
   function automatic exp_t model(input int i, input int luc, input int mw);
      exp_t e;
      bit   lu;
      lu = ex_mem_read && ex_rd != 4'hF &&
           ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd) || (id_use_rd && id_rd == ex_rd));
      e = '0;
      e.to = to_m[i];
      e.sc = 16'(sc_m[i]);
      e.fc = 16'(fc_m[i]);
      if (reset) begin
         e.nop = 1'b1;
         pend[i] = 0; frun[i] = 0; busy_prev[i] = 0; to_m[i] = 0; sc_m[i] = 0; fc_m[i] = 0;
         return e;
      end
      e.sa = busy_prev[i] || pend[i] > 0;
      if (mem_busy) begin
         e.frz = 1'b1;
         frun[i]++;
         if (frun[i] >= mw) to_m[i] = 1;
      end else begin
         frun[i] = 0;
         if (pend[i] > 0) begin
            e.nop = 1'b1;
            pend[i]--;
         end else if (lu) begin
            e.nop = 1'b1;
            pend[i] = luc - 1;
         end else begin
            e.pce = 1'b1;
            e.ife = 1'b1;
            e.fl  = branch_taken;
         end
      end
      busy_prev[i] = mem_busy;
`ifdef HAZARD_PERF_CNT_EN
      if ((e.nop || e.frz) && sc_m[i] < 65535) sc_m[i]++;
      if (e.fl && fc_m[i] < 65535) fc_m[i]++;
`endif
      return e;
   endfunction

   task automatic tick(input bit push = 1'b1);
      pair_t p;
      p.a = model(0, 3, 255);
      p.b = model(1, 1, 5);
      if (push) sbq.push_back(p);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; mem_busy = 0; ex_mem_read = 0; branch_taken = 0; ex_rd = 4'd0;
      id_rn = 4'd1; id_rm = 4'd2; id_rd = 4'd4; id_use_rn = 0; id_use_rm = 0; id_use_rd = 0;
   endtask

   task automatic load_use_on();
      ex_mem_read = 1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1;
   endtask

   task automatic check(input int i, input exp_t a, input exp_t e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL dut%0d cycle %0d: got nop=%b pc=%b ifid=%b flush=%b frz=%b sa=%b to=%b sc=%0d fc=%0d, expected nop=%b pc=%b ifid=%b flush=%b frz=%b sa=%b to=%b sc=%0d fc=%0d",
                  i, cyc, a.nop, a.pce, a.ife, a.fl, a.frz, a.sa, a.to, a.sc, a.fc,
                  e.nop, e.pce, e.ife, e.fl, e.frz, e.sa, e.to, e.sc, e.fc);
      end
   endtask

   initial begin
      pair_t p;
      forever begin
         @(negedge clk);
         cyc++;
         if (sbq.size() > 0) begin
            p = sbq.pop_front();
            check(0, {nop[0], pce[0], ife[0], fl[0], frz[0], sa[0], to[0], sc[0], fc[0]}, p.a);
            check(1, {nop[1], pce[1], ife[1], fl[1], frz[1], sa[1], to[1], sc[1], fc[1]}, p.b);
         end
      end
   end

   initial begin
      idle();
      reset = 1;
      tick(0);
      tick();
      reset = 0;
      repeat (2) tick();
      load_use_on(); tick();
      idle(); repeat (4) tick();
      load_use_on(); ex_rd = 4'hF; id_rn = 4'hF; repeat (2) tick();
      idle(); branch_taken = 1; tick();
      load_use_on(); branch_taken = 1; tick();
      idle(); repeat (4) tick();
      branch_taken = 1; tick();
      idle(); tick();
      load_use_on(); tick();
      idle(); mem_busy = 1; repeat (4) tick();
      mem_busy = 0; repeat (4) tick();
      load_use_on(); tick();
      idle(); reset = 1; tick();
      reset = 0; repeat (3) tick();
      mem_busy = 1; repeat (256) tick();
      mem_busy = 0; repeat (3) tick();
      reset = 1; tick();
      reset = 0; repeat (2) tick();
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 199) == 0);
         mem_busy     = ($urandom_range(0, 5) == 0);
         ex_mem_read  = ($urandom_range(0, 2) != 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         id_rn = 4'($urandom_range(0, 15));
         id_rm = 4'($urandom_range(0, 15));
         id_rd = 4'($urandom_range(0, 15));
         id_use_rn = 1'($urandom_range(0, 1));
         id_use_rm = 1'($urandom_range(0, 1));
         id_use_rd = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: ex_rd = id_rn;
            1: ex_rd = id_rm;
            2: ex_rd = id_rd;
            3: ex_rd = 4'hF;
            default: ex_rd = 4'($urandom_range(0, 15));
         endcase
         tick();
      end
      idle();
      repeat (3) @(negedge clk);
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
